// File: rtl/button_debounce_pulse.sv
// Synchronises, debounces and edge-detects raw push buttons into level, press and release strobes.
// Optional auto-repeat of press strobes on held buttons: define BUTTON_DEBOUNCE_AUTO_REPEAT_EN.
module button_debounce_pulse #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int REPEAT_DELAY    = 62500000,
  parameter int REPEAT_PERIOD   = 12500000
) (
  input  logic               sysclk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  (* ASYNC_REG = "TRUE" *) logic [NUM_BTN-1:0] s1_q;
  (* ASYNC_REG = "TRUE" *) logic [NUM_BTN-1:0] s2_q;

  logic [NUM_BTN-1:0]            level_q, level_d;
  logic [NUM_BTN-1:0]            press_q, press_d;
  logic [NUM_BTN-1:0]            release_q, release_d;
  logic [NUM_BTN-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_BTN-1:0]            acc_rise_s, acc_fall_s;
  logic [NUM_BTN-1:0]            rpt_fire_s;

  // Debounce: any sample matching the current level throws away accumulated credit.
  always_comb begin
    level_d    = level_q;
    cnt_d      = cnt_q;
    acc_rise_s = '0;
    acc_fall_s = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (s2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        level_d[i]    = s2_q[i];
        cnt_d[i]      = '0;
        acc_rise_s[i] = s2_q[i];
        acc_fall_s[i] = ~s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

`ifdef BUTTON_DEBOUNCE_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_HOLD_WAIT = 2'd1;
  localparam logic [1:0] ST_REPEAT    = 2'd2;

  logic [NUM_BTN-1:0][1:0]       st_q, st_d;
  logic [NUM_BTN-1:0][RPT_W-1:0] rcnt_q, rcnt_d;

  // Repeat FSM: an accepted release wins over a repeat falling due in the same cycle.
  always_comb begin
    st_d       = st_q;
    rcnt_d     = rcnt_q;
    rpt_fire_s = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (acc_fall_s[i]) begin
        st_d[i]   = ST_IDLE;
        rcnt_d[i] = '0;
      end else if (acc_rise_s[i]) begin
        st_d[i]   = ST_HOLD_WAIT;
        rcnt_d[i] = '0;
      end else begin
        case (st_q[i])
          ST_IDLE: begin
            rcnt_d[i] = '0;
          end
          ST_HOLD_WAIT: begin
            if (rcnt_q[i] == DELAY_LAST) begin
              rpt_fire_s[i] = 1'b1;
              rcnt_d[i]     = '0;
              st_d[i]       = ST_REPEAT;
            end else begin
              rcnt_d[i] = rcnt_q[i] + RPT_W'(1);
            end
          end
          ST_REPEAT: begin
            if (rcnt_q[i] == PERIOD_LAST) begin
              rpt_fire_s[i] = 1'b1;
              rcnt_d[i]     = '0;
            end else begin
              rcnt_d[i] = rcnt_q[i] + RPT_W'(1);
            end
          end
          default: begin
            st_d[i]   = ST_IDLE;
            rcnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  // Repeat state registers.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      st_q   <= {NUM_BTN{ST_IDLE}};
      rcnt_q <= '0;
    end else begin
      st_q   <= st_d;
      rcnt_q <= rcnt_d;
    end
  end
`else
  assign rpt_fire_s = '0;
`endif

  // Strobe next-state.
  always_comb begin
    press_d   = acc_rise_s | rpt_fire_s;
    release_d = acc_fall_s;
  end

  // Synchroniser, debounce state and registered outputs.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      cnt_q     <= '0;
    end else begin
      s1_q      <= btn_in;
      s2_q      <= s1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      cnt_q     <= cnt_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
endmodule

// File: tb/tb_button_debounce_pulse.sv
// Randomised and directed checks of button_debounce_pulse against a window-based reference model.
module tb_button_debounce_pulse;
  localparam int DC = 8;
  localparam int RD = 20;
  localparam int RP = 5;
  localparam int MAXE = 8192;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_in;
  logic [3:0] btn_level, btn_press, btn_release;

  button_debounce_pulse #(
    .NUM_BTN(4), .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .sysclk(clk), .rst(rst), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         edge_n = 0;
  logic [3:0] hist [0:MAXE-1];
  logic [3:0] exp_level = 4'h0;
  logic [3:0] exp_press = 4'h0;
  logic [3:0] exp_rel   = 4'h0;
  int         press_edge [4];
  int         obs_press_cnt [4];

  task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s edge=%0d got=%h exp=%h", tag, edge_n, obs, exp);
    end
  endtask

  // Reference: the synchronised value seen at edge n is the input captured two edges earlier;
  // a new level is accepted once that value has disagreed with the level for DC consecutive edges.
  task automatic model_edge();
    bit ok;
    int d;
    exp_press = 4'h0;
    exp_rel   = 4'h0;
    if (rst) begin
      hist[edge_n] = 4'h0;
      if (edge_n > 0) hist[edge_n-1] = 4'h0;
      exp_level = 4'h0;
    end else begin
      hist[edge_n] = btn_in;
      for (int ch = 0; ch < 4; ch++) begin
        ok = (edge_n >= DC + 1);
        if (ok) begin
          for (int m = edge_n - DC + 1; m <= edge_n; m++)
            if (hist[m-2][ch] == exp_level[ch]) ok = 1'b0;
        end
        if (ok) begin
          exp_level[ch] = ~exp_level[ch];
          if (exp_level[ch]) begin
            exp_press[ch]  = 1'b1;
            press_edge[ch] = edge_n;
          end else begin
            exp_rel[ch] = 1'b1;
          end
        end
`ifdef BUTTON_DEBOUNCE_AUTO_REPEAT_EN
        else if (exp_level[ch]) begin
          d = edge_n - press_edge[ch];
          if (d == RD || (d > RD && ((d - RD) % RP) == 0)) exp_press[ch] = 1'b1;
        end
`endif
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("level", btn_level, exp_level);
    check_eq("press", btn_press, exp_press);
    check_eq("release", btn_release, exp_rel);
    for (int ch = 0; ch < 4; ch++) if (btn_press[ch]) obs_press_cnt[ch]++;
    edge_n++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int ch = 0; ch < 4; ch++) begin
      press_edge[ch]    = 0;
      obs_press_cnt[ch] = 0;
    end
    rst    = 1'b1;
    btn_in = 4'hF;
    steps(3);
    check_eq("rst_level", btn_level, 4'h0);
    rst = 1'b0;
    steps(9);
    check_eq("rst_nopress", btn_press, 4'h0);
    step();
    check_eq("rst_press10", btn_press, 4'hF);
    step();
    check_eq("rst_press_1cyc", btn_press, 4'h0);

    btn_in = 4'h0;
    steps(14);
    check_eq("all_released", btn_level, 4'h0);

    btn_in[0] = 1'b1;
    steps(14);
    btn_in[0] = 1'b0;
    steps(14);

    obs_press_cnt[1] = 0;
    for (int k = 0; k < 4; k++) begin
      btn_in[1] = (k % 2 == 0);
      steps(3);
    end
    btn_in[1] = 1'b1;
    steps(14);
    check_eq("bounce_one_press", 4'(obs_press_cnt[1]), 4'd1);

    btn_in[3] = 1'b1;
    steps(14);
    btn_in[2] = 1'b1;
    btn_in[3] = 1'b0;
    steps(9);
    step();
    check_eq("simul_press", btn_press, 4'h4);
    check_eq("simul_release", btn_release, 4'h8);
    steps(3);

    btn_in[0] = 1'b1;
    steps(7);
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
    steps(14);

`ifdef BUTTON_DEBOUNCE_AUTO_REPEAT_EN
    btn_in = 4'h0;
    steps(14);
    btn_in[0] = 1'b1;
    steps(55);
    btn_in[0] = 1'b0;
    steps(20);
`endif

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) btn_in[$urandom_range(0, 3)] ^= 1'b1;
      rst = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0;
    steps(14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
